// File: rtl/block_0_reg_initiator.sv
// block_0_reg_initiator: one-command-at-a-time register bus initiator
// supporting read, write, read-modify-write and bounded poll-until-match.
module block_0_reg_initiator #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_LIMIT = 16,
  parameter int POLL_GAP = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [1:0]                i_cmd_op,
  input  logic [ADDRESS_WIDTH-1:0]  i_cmd_address,
  input  logic [DATA_WIDTH-1:0]     i_cmd_data,
  input  logic [DATA_WIDTH-1:0]     i_cmd_mask,
  input  logic [DATA_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                      o_bus_valid,
  output logic                      o_bus_write,
  output logic [ADDRESS_WIDTH-1:0]  o_bus_address,
  output logic [DATA_WIDTH-1:0]     o_bus_write_data,
  output logic [DATA_WIDTH/8-1:0]   o_bus_strobe,
  input  logic                      i_bus_ready,
  input  logic [1:0]                i_bus_status,
  input  logic [DATA_WIDTH-1:0]     i_bus_read_data,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [1:0]                o_rsp_status,
  output logic [DATA_WIDTH-1:0]     o_rsp_data,
  output logic                      o_busy
);
  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [1:0] OP_READ = 2'b00, OP_WRITE = 2'b01, OP_RMW = 2'b10, OP_POLL = 2'b11;
  typedef enum logic [2:0] {IDLE, RD, WR, GAP, RESP} state_t;
  state_t state, state_n;
  logic [1:0] op;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data, mask, rmw_data;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap;
  logic bus_err, poll_miss;
  assign o_cmd_ready = state == IDLE;
  assign o_busy = state != IDLE;
  always_comb begin
    bus_err = i_bus_status[1];
    poll_miss = op == OP_POLL && ((i_bus_read_data ^ data) & mask) != '0;
    rmw_data = (i_bus_read_data & ~mask) | (data & mask);
    state_n = state;
    case (state)
      IDLE: if (i_cmd_valid) state_n = i_cmd_op == OP_WRITE ? WR : RD;
      RD: if (i_bus_ready) state_n = (bus_err || op == OP_READ) ? RESP :
                                     op == OP_RMW ? WR :
                                     (!poll_miss || cnt == CW'(POLL_LIMIT - 1)) ? RESP : GAP;
      WR: if (i_bus_ready) state_n = RESP;
      GAP: if (gap == GW'(POLL_GAP - 1)) state_n = RD;
      RESP: if (i_rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  // Bus and response registers load only on phase entry so they stay stable while held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op <= '0;
      addr <= '0;
      data <= '0;
      mask <= '0;
      strobe <= '0;
      cnt <= '0;
      gap <= '0;
      o_bus_valid <= 1'b0;
      o_bus_write <= 1'b0;
      o_bus_address <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_status <= '0;
      o_rsp_data <= '0;
    end else begin
      if (state == IDLE && i_cmd_valid) begin
        op <= i_cmd_op;
        addr <= i_cmd_address;
        data <= i_cmd_data;
        mask <= i_cmd_mask;
        strobe <= i_cmd_strobe;
        cnt <= '0;
      end else if (state == RD && i_bus_ready) begin
        cnt <= cnt + 1'b1;
      end
      gap <= state == GAP ? gap + 1'b1 : '0;
      o_bus_valid <= state_n == RD || state_n == WR;
      o_bus_write <= state_n == WR;
      if (state_n == RD && state != RD) begin
        o_bus_address <= state == IDLE ? i_cmd_address : addr;
        o_bus_strobe <= '0;
      end
      if (state_n == WR && state != WR) begin
        o_bus_address <= state == IDLE ? i_cmd_address : addr;
        o_bus_write_data <= state == IDLE ? i_cmd_data : rmw_data;
        o_bus_strobe <= state == IDLE ? i_cmd_strobe : strobe;
      end
      o_rsp_valid <= state_n == RESP;
      if (state_n == RESP && state != RESP) begin
        o_rsp_status <= bus_err ? i_bus_status : poll_miss ? 2'b01 : 2'b00;
        o_rsp_data <= state == WR ? o_bus_write_data : i_bus_read_data;
      end
    end
  end
endmodule

// File: tb/tb_block_0_reg_initiator.sv
// tb_block_0_reg_initiator: directed scenarios against a small bus responder model.
module tb_block_0_reg_initiator;
  logic clk = 1'b0;
  logic rst;
  logic i_cmd_valid, o_cmd_ready;
  logic [1:0] i_cmd_op;
  logic [7:0] i_cmd_address;
  logic [31:0] i_cmd_data, i_cmd_mask;
  logic [3:0] i_cmd_strobe;
  logic o_bus_valid, o_bus_write;
  logic [7:0] o_bus_address;
  logic [31:0] o_bus_write_data;
  logic [3:0] o_bus_strobe;
  logic i_bus_ready;
  logic [1:0] i_bus_status;
  logic [31:0] i_bus_read_data;
  logic o_rsp_valid, i_rsp_ready;
  logic [1:0] o_rsp_status;
  logic [31:0] o_rsp_data;
  logic o_busy;
  int cmp = 0, bad = 0, cyc = 0;
  int wait_cycles = 0, waited = 0, n_rd = 0, n_wr = 0, vcyc = 0, last_vcyc = 0, start = 0;
  bit in_txn = 0, unstable = 0;
  logic [7:0] a0, wr_addr, rd_addr;
  logic w0;
  logic [31:0] d0, wr_data;
  logic [3:0] s0, wr_strobe, rd_strobe;
  logic [1:0] wr_status = 2'b00;
  logic [31:0] rd_data [0:31];
  logic [1:0] rd_status [0:31];
  int rd_start [0:31];
  int rd_done [0:31];

  block_0_reg_initiator dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_address(i_cmd_address), .i_cmd_data(i_cmd_data), .i_cmd_mask(i_cmd_mask),
    .i_cmd_strobe(i_cmd_strobe),
    .o_bus_valid(o_bus_valid), .o_bus_write(o_bus_write), .o_bus_address(o_bus_address),
    .o_bus_write_data(o_bus_write_data), .o_bus_strobe(o_bus_strobe),
    .i_bus_ready(i_bus_ready), .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_status(o_rsp_status),
    .o_rsp_data(o_rsp_data), .o_busy(o_busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Bus responder: acks after wait_cycles, checks request stability, logs transfers.
  initial begin
    i_bus_ready = 1'b0;
    i_bus_status = 2'b00;
    i_bus_read_data = '0;
    forever begin
      @(negedge clk);
      if (i_bus_ready) begin
        i_bus_ready = 1'b0;
      end else if (o_bus_valid) begin
        if (!in_txn) begin
          in_txn = 1;
          start = cyc;
          waited = 0;
          vcyc = 0;
          a0 = o_bus_address;
          w0 = o_bus_write;
          d0 = o_bus_write_data;
          s0 = o_bus_strobe;
        end
        vcyc++;
        if (o_bus_address !== a0 || o_bus_write !== w0 || o_bus_write_data !== d0 || o_bus_strobe !== s0)
          unstable = 1;
        if (waited >= wait_cycles) begin
          i_bus_ready = 1'b1;
          in_txn = 0;
          last_vcyc = vcyc;
          if (w0) begin
            i_bus_status = wr_status;
            wr_addr = a0;
            wr_data = d0;
            wr_strobe = s0;
            n_wr++;
          end else begin
            i_bus_status = rd_status[n_rd];
            i_bus_read_data = rd_data[n_rd];
            rd_addr = a0;
            rd_strobe = s0;
            rd_start[n_rd] = start;
            rd_done[n_rd] = cyc;
            n_rd++;
          end
        end else begin
          waited++;
        end
      end else begin
        in_txn = 0;
      end
    end
  end

  task automatic clear_log();
    n_rd = 0;
    n_wr = 0;
    unstable = 0;
    wr_status = 2'b00;
    for (int i = 0; i < 32; i++) begin
      rd_data[i] = '0;
      rd_status[i] = 2'b00;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] m, input logic [3:0] s);
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_op = op;
    i_cmd_address = a;
    i_cmd_data = d;
    i_cmd_mask = m;
    i_cmd_strobe = s;
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output logic [1:0] st, output logic [31:0] dt,
                          output int lat, output bit got, output logic ra);
    lat = 1;
    got = 0;
    st = 2'b00;
    dt = '0;
    ra = 1'b0;
    while (!o_rsp_valid && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    if (o_rsp_valid) begin
      got = 1;
      st = o_rsp_status;
      dt = o_rsp_data;
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
      ra = o_cmd_ready && !o_rsp_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_op = 2'b00;
    i_cmd_address = 8'h08;
    repeat (3) @(negedge clk);
    cmp++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    cmp++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready); end
    cmp++; if ({o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe} !== '0)
      begin bad++; $display("FAIL reset_bus: got %b/%b/%h/%h/%h want all 0", o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe); end
    cmp++; if ({o_rsp_valid, o_rsp_status, o_rsp_data} !== '0)
      begin bad++; $display("FAIL reset_rsp: got %b/%h/%h want all 0", o_rsp_valid, o_rsp_status, o_rsp_data); end
    i_cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    cmp++; if (o_busy !== 1'b0 || n_rd !== 0) begin bad++; $display("FAIL reset_no_accept: busy %b reads %0d want 0/0", o_busy, n_rd); end
  endtask

  task automatic test_read();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 3;
    rd_data[0] = 32'h00AB_CD0F;
    issue(2'b00, 8'h08, 32'h0, 32'h0, 4'hF);
    cmp++; if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0) begin bad++; $display("FAIL read_busy: busy %b ready %b want 1/0", o_busy, o_cmd_ready); end
    wait_rsp(100, st, dt, lat, got, ra);
    cmp++; if (!got) begin bad++; $display("FAIL read_rsp: got none want response"); end
    cmp++; if (st !== 2'b00 || dt !== 32'h00AB_CD0F) begin bad++; $display("FAIL read_result: got %b/%h want 00/00abcd0f", st, dt); end
    cmp++; if (n_rd !== 1 || n_wr !== 0) begin bad++; $display("FAIL read_count: got %0d rd %0d wr want 1/0", n_rd, n_wr); end
    cmp++; if (rd_addr !== 8'h08 || rd_strobe !== 4'h0) begin bad++; $display("FAIL read_addr: got %h/%h want 08/0", rd_addr, rd_strobe); end
    cmp++; if (last_vcyc !== 4 || unstable) begin bad++; $display("FAIL read_hold: got %0d cycles unstable %b want 4/0", last_vcyc, unstable); end
    cmp++; if (ra !== 1'b1) begin bad++; $display("FAIL read_ready_after: got %b want 1", ra); end
  endtask

  task automatic test_exokay();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 0;
    rd_data[0] = 32'h1111_2222;
    rd_status[0] = 2'b01;
    issue(2'b00, 8'h10, 32'h0, 32'h0, 4'h0);
    wait_rsp(100, st, dt, lat, got, ra);
    cmp++; if (!got || st !== 2'b00 || dt !== 32'h1111_2222) begin bad++; $display("FAIL exokay: got %0d %b/%h want 1 00/11112222", got, st, dt); end
    cmp++; if (lat !== 2) begin bad++; $display("FAIL read_latency: got %0d want 2", lat); end
  endtask

  task automatic test_write();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 0;
    issue(2'b01, 8'h1C, 32'h0F0F_0F0F, 32'h0, 4'b0101);
    wait_rsp(100, st, dt, lat, got, ra);
    cmp++; if (!got || st !== 2'b00 || dt !== 32'h0F0F_0F0F) begin bad++; $display("FAIL write_result: got %0d %b/%h want 1 00/0f0f0f0f", got, st, dt); end
    cmp++; if (n_wr !== 1 || n_rd !== 0) begin bad++; $display("FAIL write_count: got %0d wr %0d rd want 1/0", n_wr, n_rd); end
    cmp++; if (wr_addr !== 8'h1C || wr_data !== 32'h0F0F_0F0F || wr_strobe !== 4'b0101)
      begin bad++; $display("FAIL write_bus: got %h/%h/%b want 1c/0f0f0f0f/0101", wr_addr, wr_data, wr_strobe); end
    cmp++; if (lat !== 2) begin bad++; $display("FAIL write_latency: got %0d want 2", lat); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 1;
    issue(2'b01, 8'h20, 32'hA5A5_A5A5, 32'h0, 4'b1111);
    wait_rsp(100, st, dt, lat, got, ra);
    cmp++; if (!got || ra !== 1'b1) begin bad++; $display("FAIL b2b_first: got %0d ready %b want 1/1", got, ra); end
    wr_status = 2'b10;
    issue(2'b01, 8'h24, 32'h5A5A_5A5A, 32'h0, 4'b0011);
    wait_rsp(100, st, dt, lat, got, ra);
    cmp++; if (!got || st !== 2'b10 || dt !== 32'h5A5A_5A5A) begin bad++; $display("FAIL b2b_second: got %0d %b/%h want 1 10/5a5a5a5a", got, st, dt); end
    cmp++; if (n_wr !== 2 || wr_addr !== 8'h24 || wr_strobe !== 4'b0011)
      begin bad++; $display("FAIL b2b_bus: got %0d %h %b want 2 24 0011", n_wr, wr_addr, wr_strobe); end
  endtask

  task automatic test_rmw();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 0;
    rd_data[0] = 32'h1234_5678;
    issue(2'b10, 8'h30, 32'h0000_0050, 32'h0000_00F0, 4'hF);
    wait_rsp(100, st, dt, lat, got, ra);
    cmp++; if (!got || st !== 2'b00 || dt !== 32'h1234_5658) begin bad++; $display("FAIL rmw_result: got %0d %b/%h want 1 00/12345658", got, st, dt); end
    cmp++; if (n_rd !== 1 || n_wr !== 1) begin bad++; $display("FAIL rmw_count: got %0d rd %0d wr want 1/1", n_rd, n_wr); end
    cmp++; if (wr_addr !== 8'h30 || wr_data !== 32'h1234_5658 || wr_strobe !== 4'hF)
      begin bad++; $display("FAIL rmw_write: got %h/%h/%h want 30/12345658/f", wr_addr, wr_data, wr_strobe); end
  endtask

  task automatic test_rmw_error();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 0;
    rd_data[0] = 32'hDEAD_BEEF;
    rd_status[0] = 2'b11;
    issue(2'b10, 8'h34, 32'h1, 32'h1, 4'hF);
    wait_rsp(100, st, dt, lat, got, ra);
    cmp++; if (!got || st !== 2'b11 || dt !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rmw_err_result: got %0d %b/%h want 1 11/deadbeef", got, st, dt); end
    cmp++; if (n_wr !== 0) begin bad++; $display("FAIL rmw_err_nowrite: got %0d writes want 0", n_wr); end
  endtask

  task automatic test_reset_mid_rmw();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 50;
    issue(2'b10, 8'h44, 32'h1, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    cmp++; if (o_bus_valid !== 1'b1) begin bad++; $display("FAIL mid_valid: got %b want 1", o_bus_valid); end
    rst = 1'b1;
    #1;
    cmp++; if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL mid_reset_state: ready %b busy %b want 1/0", o_cmd_ready, o_busy); end
    cmp++; if ({o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe} !== '0)
      begin bad++; $display("FAIL mid_reset_bus: got %b/%b/%h/%h/%h want all 0", o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe); end
    cmp++; if ({o_rsp_valid, o_rsp_status, o_rsp_data} !== '0)
      begin bad++; $display("FAIL mid_reset_rsp: got %b/%h/%h want all 0", o_rsp_valid, o_rsp_status, o_rsp_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp++; if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL mid_discard: rsp %b busy %b want 0/0", o_rsp_valid, o_busy); end
    clear_log();
    wait_cycles = 0;
    rd_data[0] = 32'hCAFE_0001;
    issue(2'b00, 8'h24, 32'h0, 32'h0, 4'h0);
    wait_rsp(100, st, dt, lat, got, ra);
    cmp++; if (!got || st !== 2'b00 || dt !== 32'hCAFE_0001) begin bad++; $display("FAIL mid_new_read: got %0d %b/%h want 1 00/cafe0001", got, st, dt); end
    cmp++; if (n_rd !== 1 || n_wr !== 0 || rd_addr !== 8'h24) begin bad++; $display("FAIL mid_new_bus: got %0d/%0d/%h want 1/0/24", n_rd, n_wr, rd_addr); end
  endtask

  task automatic test_poll_match();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 0;
    rd_data[0] = 32'h10;
    rd_data[1] = 32'h2;
    rd_data[2] = 32'h5;
    issue(2'b11, 8'h04, 32'h1, 32'h1, 4'hF);
    wait_rsp(500, st, dt, lat, got, ra);
    cmp++; if (!got || st !== 2'b00 || dt !== 32'h5) begin bad++; $display("FAIL poll_result: got %0d %b/%h want 1 00/5", got, st, dt); end
    cmp++; if (n_rd !== 3 || rd_addr !== 8'h04) begin bad++; $display("FAIL poll_reads: got %0d at %h want 3 at 04", n_rd, rd_addr); end
    cmp++; if (rd_start[1] - rd_done[0] < 5 || rd_start[2] - rd_done[1] < 5)
      begin bad++; $display("FAIL poll_gap: got %0d/%0d want >=5", rd_start[1] - rd_done[0], rd_start[2] - rd_done[1]); end
  endtask

  task automatic test_poll_timeout();
    logic [1:0] st; logic [31:0] dt; int lat; bit got; logic ra;
    clear_log();
    wait_cycles = 0;
    for (int i = 0; i < 32; i++) rd_data[i] = 32'(i * 2);
    issue(2'b11, 8'h04, 32'h1, 32'h1, 4'hF);
    wait_rsp(1000, st, dt, lat, got, ra);
    cmp++; if (!got || st !== 2'b01 || dt !== 32'h1E) begin bad++; $display("FAIL poll_timeout: got %0d %b/%h want 1 01/1e", got, st, dt); end
    repeat (10) @(negedge clk);
    cmp++; if (n_rd !== 16 || n_wr !== 0) begin bad++; $display("FAIL poll_timeout_reads: got %0d rd %0d wr want 16/0", n_rd, n_wr); end
  endtask

  initial begin
    i_cmd_valid = 1'b0;
    i_cmd_op = 2'b00;
    i_cmd_address = '0;
    i_cmd_data = '0;
    i_cmd_mask = '0;
    i_cmd_strobe = '0;
    i_rsp_ready = 1'b0;
    test_reset();
    test_read();
    test_exokay();
    test_write();
    test_back_to_back();
    test_rmw();
    test_rmw_error();
    test_reset_mid_rmw();
    test_poll_match();
    test_poll_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
